// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with stall, redirect, sticky halt
// and an optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               INC       = 2,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             push_ret,
  input  logic             pop_ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_uflow
);

  typedef enum logic {RUN, HALTED} state_e;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             active;
  logic             pop_hit;
  logic [WIDTH-1:0] ras_top;

  // Only a running, unstalled cycle may change any state.
  assign active = (state_q == RUN) && !stall;
  assign pc_seq = pc_q + INC_W;
  assign pc     = pc_q;
  assign halted = (state_q == HALTED);

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    top_idx;
  logic [PW:0]      cnt_q;
  logic             uflow_q;
  logic             nonempty;
  logic             do_push;
  logic             do_pop;

  assign nonempty  = (cnt_q != '0);
  assign top_idx   = wr_ptr_q - 1'b1;
  assign ras_top   = ras_q[top_idx];
  assign do_push   = active && push_ret;
  assign do_pop    = active && pop_ret;
  assign pop_hit   = do_pop && nonempty;
  assign ras_empty = !nonempty;
  assign ras_full  = (cnt_q == DEPTH_C);
  assign ras_uflow = uflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      uflow_q  <= 1'b0;
    end else begin
      if (do_push && pop_hit) begin
        wr_ptr_q <= wr_ptr_q;
      end else if (do_push) begin
        // A full stack wraps onto its oldest slot; the count saturates.
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (cnt_q != DEPTH_C) cnt_q <= cnt_q + 1'b1;
      end else if (pop_hit) begin
        wr_ptr_q <= top_idx;
        cnt_q    <= cnt_q - 1'b1;
      end
      if (do_pop && !nonempty) uflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && pop_hit) begin
      ras_q[top_idx] <= pc_seq;
    end else if (do_push) begin
      ras_q[wr_ptr_q] <= pc_seq;
    end
  end
`else
  logic unused_ras;

  assign unused_ras = push_ret ^ pop_ret;
  assign pop_hit    = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_uflow  = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (active) begin
      if (redirect)     pc_d = redirect_pc;
      else if (pop_hit) pc_d = ras_top;
      else              pc_d = pc_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      if (active && halt) state_q <= HALTED;
    end
  end

endmodule
